// File: rtl/serial_lim_output_pkg.sv
// Shared definitions for the serial limit output block: FSM encoding and control register layout.
// No logic here; imported by the top and the tick generator.
package serial_lim_output_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [2:0] CTRL_INDEX      = 3'd7;
    localparam int         CTRL_UPDATE_BIT = 0;
    localparam int         CTRL_AUTO_BIT   = 1;

    // A zero divider would never tick; run it as divide-by-one instead.
    function automatic int eff_div(input int div);
        return (div <= 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV clocks while enabled.
// Counter restarts on every tick and is held at zero while clear is high.
module serial_tick_gen
    import serial_lim_output_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int DIV = eff_div(CLK_DIV);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_lim_output.sv
// AHB-programmed staging register streamed MSB-first to CHANNEL_NUM SIPO chains, then latched.
// AHB never stalls (hreadyout=1); update requests arriving while busy coalesce into one pending transfer.
module serial_lim_output
    import serial_lim_output_pkg::*;
#(
    parameter int CHANNEL_NUM   = 6,
    parameter int CHANNEL_DEPTH = 8,
    parameter int CLK_DIV       = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ahb_addr_valid,
    input  logic [1:0]             mem_ahb_htrans,
    input  logic                   mem_ahb_hready,
    input  logic                   mem_ahb_hwrite,
    input  logic [31:0]            mem_ahb_haddr,
    input  logic [2:0]             mem_ahb_hsize,
    input  logic [2:0]             mem_ahb_hburst,
    input  logic [31:0]            mem_ahb_hwdata,
    output logic                   mem_ahb_hreadyout,
    output logic                   mem_ahb_hresp,
    output logic [31:0]            mem_ahb_hrdata,
    input  logic                   trigger,
    output logic [CHANNEL_NUM-1:0] serial_data_out,
    output logic                   shift,
    output logic                   latch,
    output logic                   out_en_n
);

    localparam int         DATA_WIDTH = CHANNEL_NUM * CHANNEL_DEPTH;
    localparam int         WORDS      = (DATA_WIDTH + 31) / 32;
    localparam logic [2:0] WORDS_IDX  = 3'(WORDS);
    localparam int         BW         = $clog2(CHANNEL_DEPTH + 1);
    localparam logic [BW-1:0] BIT_END = BW'(CHANNEL_DEPTH);

    if (WORDS > 7) begin : g_words_check
        $error("serial_lim_output: staging needs more than 7 words");
    end

    logic unused_inputs;
    assign unused_inputs = ^{mem_ahb_hsize, mem_ahb_hburst, mem_ahb_haddr[31:5],
                             mem_ahb_haddr[1:0], mem_ahb_htrans[0]};

    assign mem_ahb_hreadyout = 1'b1;
    assign mem_ahb_hresp     = 1'b0;

    logic                  addr_ph, wr_ph, rd_ph;
    logic [2:0]            rd_idx;
    logic                  wr_pend;
    logic [2:0]            wr_idx;
    logic [DATA_WIDTH-1:0] staging, staging_wr, shadow;
    logic                  auto_update, sw_req, pending, busy;
    logic [31:0]           rdata;
    logic [2:0]            trig_sync;
    logic                  trig_rise, req;
    state_t                state, state_n;
    logic                  phase, phase_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic                  start, latch_done, tick;

    assign addr_ph   = ahb_addr_valid & mem_ahb_htrans[1] & mem_ahb_hready;
    assign wr_ph     = addr_ph & mem_ahb_hwrite;
    assign rd_ph     = addr_ph & ~mem_ahb_hwrite;
    assign rd_idx    = mem_ahb_haddr[4:2];
    assign busy      = (state != ST_IDLE);
    assign trig_rise = trig_sync[1] & ~trig_sync[2];
    assign req       = sw_req | trig_rise;

    always_comb begin
        staging_wr = staging;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (wr_idx == 3'(b / 32)) staging_wr[b] = mem_ahb_hwdata[b % 32];
        end
    end

    always_comb begin
        rdata = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (rd_idx == 3'(b / 32)) rdata[b % 32] = staging[b];
        end
        if (rd_idx == CTRL_INDEX) rdata = {29'b0, auto_update, pending, busy};
    end

    // Write data arrives one cycle after its address phase; software requests are
    // registered so the snapshot always sees the staging value that caused them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_pend        <= 1'b0;
            wr_idx         <= '0;
            staging        <= '0;
            auto_update    <= 1'b0;
            sw_req         <= 1'b0;
            mem_ahb_hrdata <= '0;
            trig_sync      <= '0;
        end else begin
            wr_pend   <= wr_ph;
            trig_sync <= {trig_sync[1:0], trigger};
            sw_req    <= 1'b0;
            if (wr_ph) wr_idx <= mem_ahb_haddr[4:2];
            if (wr_pend) begin
                if (wr_idx == CTRL_INDEX) begin
                    auto_update <= mem_ahb_hwdata[CTRL_AUTO_BIT];
                    sw_req      <= mem_ahb_hwdata[CTRL_UPDATE_BIT];
                end else if (wr_idx < WORDS_IDX) begin
                    staging <= staging_wr;
                    sw_req  <= auto_update;
                end
            end
            if (rd_ph) mem_ahb_hrdata <= rdata;
        end
    end

    serial_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (reset_n),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        bit_n      = bit_cnt;
        start      = 1'b0;
        latch_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req || pending) begin
                    state_n = ST_SHIFT;
                    phase_n = 1'b0;
                    bit_n   = '0;
                    start   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (phase) begin
                        phase_n = 1'b0;
                        bit_n   = bit_cnt + 1'b1;
                    end else if (bit_cnt == BIT_END) begin
                        state_n = ST_LATCH;
                    end else begin
                        phase_n = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_n    = ST_IDLE;
                    latch_done = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            pending  <= 1'b0;
            shadow   <= '0;
            out_en_n <= 1'b1;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            if (start) begin
                shadow  <= staging;
                pending <= 1'b0;
            end else if (req && busy) begin
                pending <= 1'b1;
            end
            if (latch_done) out_en_n <= 1'b0;
        end
    end

    always_comb begin
        serial_data_out = '0;
        shift           = (state == ST_SHIFT) & phase;
        latch           = (state == ST_LATCH);
        if (state == ST_SHIFT) begin
            for (int n = 0; n < CHANNEL_NUM; n++) begin
                for (int k = 0; k < CHANNEL_DEPTH; k++) begin
                    if (bit_cnt == BW'(k))
                        serial_data_out[n] = shadow[n*CHANNEL_DEPTH + CHANNEL_DEPTH - 1 - k];
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_lim_output.sv
// Randomised bench for serial_lim_output: a monitor rebuilds each streamed snapshot from shift
// rising edges and scenario tasks compare it against a staging-register model kept here.
module tb_serial_lim_output;

    localparam int CN   = 6;
    localparam int CD   = 8;
    localparam int CDIV = 10;
    localparam int DW   = CN * CD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ahb_addr_valid = 1'b0;
    logic [1:0]    htrans = 2'b00;
    logic          hready = 1'b1;
    logic          hwrite = 1'b0;
    logic [31:0]   haddr = '0;
    logic [2:0]    hsize = 3'd2;
    logic [2:0]    hburst = 3'd0;
    logic [31:0]   hwdata = '0;
    logic          hreadyout, hresp;
    logic [31:0]   hrdata;
    logic          trigger = 1'b0;
    logic [CN-1:0] serial_data_out;
    logic          shift, latch, out_en_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model_stage = '0;
    logic          model_auto  = 1'b0;

    logic [DW-1:0] got_q[$];
    int            rise_q[$];
    int            lat_q[$];
    time           end_q[$];
    int            timing_bad = 0;

    always #5 clk = ~clk;

    serial_lim_output #(
        .CHANNEL_NUM   (CN),
        .CHANNEL_DEPTH (CD),
        .CLK_DIV       (CDIV)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ahb_addr_valid    (ahb_addr_valid),
        .mem_ahb_htrans    (htrans),
        .mem_ahb_hready    (hready),
        .mem_ahb_hwrite    (hwrite),
        .mem_ahb_haddr     (haddr),
        .mem_ahb_hsize     (hsize),
        .mem_ahb_hburst    (hburst),
        .mem_ahb_hwdata    (hwdata),
        .mem_ahb_hreadyout (hreadyout),
        .mem_ahb_hresp     (hresp),
        .mem_ahb_hrdata    (hrdata),
        .trigger           (trigger),
        .serial_data_out   (serial_data_out),
        .shift             (shift),
        .latch             (latch),
        .out_en_n          (out_en_n)
    );

    // Monitor: every shift rise captures one bit per lane (MSB first); a latch fall closes a transfer.
    logic          p_shift = 1'b0, p_latch = 1'b0;
    int            rise_cnt = 0, lo_run = 0, hi_run = 0, lat_run = 0;
    logic [DW-1:0] cur = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            p_shift = 1'b0; p_latch = 1'b0; rise_cnt = 0;
            lo_run = 0; hi_run = 0; lat_run = 0; cur = '0;
        end else begin
            if (latch) begin
                if (!p_latch && lo_run != CDIV) timing_bad++;
                lat_run++;
            end else if (p_latch) begin
                got_q.push_back(cur);
                rise_q.push_back(rise_cnt);
                lat_q.push_back(lat_run);
                end_q.push_back($time);
                cur = '0; rise_cnt = 0; lat_run = 0;
            end
            if (shift) begin
                if (!p_shift) begin
                    if (rise_cnt > 0 && lo_run != CDIV) timing_bad++;
                    if (rise_cnt < CD)
                        for (int n = 0; n < CN; n++) cur[n*CD + CD - 1 - rise_cnt] = serial_data_out[n];
                    rise_cnt++;
                    hi_run = 0;
                end
                hi_run++;
                lo_run = 0;
            end else begin
                if (p_shift) begin
                    if (hi_run != CDIV) timing_bad++;
                    lo_run = 0;
                end
                lo_run++;
            end
            p_shift = shift;
            p_latch = latch;
        end
    end

    task automatic ahb_write(input logic [2:0] idx, input logic [31:0] d);
        logic [63:0] pad;
        @(negedge clk);
        ahb_addr_valid = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = {27'b0, idx, 2'b00};
        @(negedge clk);
        ahb_addr_valid = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(negedge clk);
        if (idx < 3'd2) begin
            pad = {16'b0, model_stage};
            pad[idx*32 +: 32] = d;
            model_stage = pad[DW-1:0];
        end
        if (idx == 3'd7) model_auto = d[1];
    endtask

    task automatic ahb_read(input logic [2:0] idx, output logic [31:0] d);
        @(negedge clk);
        ahb_addr_valid = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = {27'b0, idx, 2'b00};
        @(negedge clk);
        ahb_addr_valid = 1'b0; htrans = 2'b00;
        d = hrdata;
    endtask

    task automatic pulse_trigger();
        @(negedge clk);
        #2 trigger = 1'b1;
        repeat (4) @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int c = 0;
        while (got_q.size() < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : 'x;
    endfunction

    task automatic test_reset();
        logic [31:0] r;
        @(negedge clk);
        n_checks++;
        if ({shift, latch, serial_data_out, out_en_n} !== {1'b0, 1'b0, {CN{1'b0}}, 1'b1})
            $display("FAIL reset_outputs: got shift=%b latch=%b sdo=%b oen=%b, want 0 0 0 1",
                     shift, latch, serial_data_out, out_en_n);
        else n_pass++;
        n_checks++;
        if ({hreadyout, hresp, hrdata} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL reset_ahb: got hreadyout=%b hresp=%b hrdata=%h", hreadyout, hresp, hrdata);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ahb_read(3'd7, r);
        n_checks++;
        if (r !== 32'h0) $display("FAIL reset_ctrl_read: got %h, want 00000000", r); else n_pass++;
        ahb_read(3'd0, r);
        n_checks++;
        if (r !== 32'h0) $display("FAIL reset_word0_read: got %h, want 00000000", r); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0]   r, w1;
        logic [DW-1:0] exp, g;
        int            base, len;
        time           t0;
        w1 = $urandom;
        ahb_write(3'd0, 32'h0403_0201);
        ahb_write(3'd1, w1);
        exp  = model_stage;
        base = got_q.size();
        ahb_write(3'd7, 32'h1);
        t0 = $time;
        wait_xfers(base + 1, 400);
        g = got_at(base);
        n_checks++;
        if (got_q.size() !== base + 1) $display("FAIL basic_count: got %0d transfers, want %0d", got_q.size() - base, 1);
        else n_pass++;
        n_checks++;
        if (g[7:0] !== 8'h01) $display("FAIL basic_lane0_stream: got %b, want 00000001", g[7:0]); else n_pass++;
        n_checks++;
        if (g !== exp) $display("FAIL basic_snapshot: got %h, want %h", g, exp); else n_pass++;
        n_checks++;
        if ((rise_q.size() > base ? rise_q[base] : -1) !== CD)
            $display("FAIL basic_rises: got %0d, want %0d", rise_q.size() > base ? rise_q[base] : -1, CD);
        else n_pass++;
        n_checks++;
        if ((lat_q.size() > base ? lat_q[base] : -1) !== CDIV)
            $display("FAIL basic_latch_len: got %0d, want %0d", lat_q.size() > base ? lat_q[base] : -1, CDIV);
        else n_pass++;
        n_checks++;
        if (timing_bad !== 0) $display("FAIL basic_half_periods: %0d bad half periods, want 0", timing_bad); else n_pass++;
        len = (end_q.size() > base) ? int'((end_q[base] - t0) / 10) : -1;
        n_checks++;
        if (len < CD*2*CDIV + 2*CDIV - 2 || len > CD*2*CDIV + 2*CDIV + 2)
            $display("FAIL basic_total_len: got %0d clk, want %0d +-2", len, CD*2*CDIV + 2*CDIV);
        else n_pass++;
        n_checks++;
        if ({out_en_n, shift, latch, serial_data_out} !== '0)
            $display("FAIL basic_idle_outputs: got oen=%b shift=%b latch=%b sdo=%b, want all 0",
                     out_en_n, shift, latch, serial_data_out);
        else n_pass++;
        ahb_read(3'd7, r);
        n_checks++;
        if (r !== 32'h0) $display("FAIL basic_not_busy: got %h, want 00000000", r); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0]   r;
        logic [DW-1:0] exp;
        int            base;
        for (int it = 0; it < 4; it++) begin
            ahb_write(3'd0, $urandom);
            ahb_write(3'd1, $urandom);
            exp  = model_stage;
            base = got_q.size();
            if (it % 2 == 0) ahb_write(3'd7, 32'h1);
            else pulse_trigger();
            wait_xfers(base + 1, 400);
            n_checks++;
            if (got_at(base) !== exp) $display("FAIL random_snapshot_%0d: got %h, want %h", it, got_at(base), exp);
            else n_pass++;
            ahb_read(3'd1, r);
            n_checks++;
            if (r !== {16'b0, model_stage[47:32]}) $display("FAIL random_word1_read_%0d: got %h, want %h", it, r, {16'b0, model_stage[47:32]});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]   r;
        logic [DW-1:0] exp1, exp2;
        int            base;
        ahb_write(3'd0, $urandom);
        exp1 = model_stage;
        base = got_q.size();
        ahb_write(3'd7, 32'h1);
        repeat (30) @(negedge clk);
        ahb_write(3'd7, 32'h1);
        ahb_write(3'd0, $urandom);
        ahb_write(3'd7, 32'h1);
        ahb_write(3'd7, 32'h1);
        exp2 = model_stage;
        ahb_read(3'd7, r);
        n_checks++;
        if (r !== 32'h3) $display("FAIL coalesce_status: got %h, want 00000003", r); else n_pass++;
        wait_xfers(base + 2, 800);
        repeat (300) @(negedge clk);
        n_checks++;
        if (got_q.size() !== base + 2) $display("FAIL coalesce_count: got %0d transfers, want 2", got_q.size() - base);
        else n_pass++;
        n_checks++;
        if (got_at(base) !== exp1) $display("FAIL coalesce_first: got %h, want %h", got_at(base), exp1); else n_pass++;
        n_checks++;
        if (got_at(base + 1) !== exp2) $display("FAIL coalesce_second: got %h, want %h", got_at(base + 1), exp2); else n_pass++;
    endtask

    task automatic test_latch_boundary();
        int base, c;
        for (int off = 3; off <= 9; off++) begin
            ahb_write(3'd0, $urandom);
            base = got_q.size();
            ahb_write(3'd7, 32'h1);
            c = 0;
            while (!latch && c < 400) begin @(negedge clk); c++; end
            repeat (off) @(negedge clk);
            ahb_write(3'd7, 32'h1);
            wait_xfers(base + 2, 600);
            repeat (20) @(negedge clk);
            n_checks++;
            if (got_q.size() !== base + 2)
                $display("FAIL latch_edge_count_off%0d: got %0d transfers, want 2", off, got_q.size() - base);
            else n_pass++;
            n_checks++;
            if (got_at(base + 1) !== model_stage)
                $display("FAIL latch_edge_data_off%0d: got %h, want %h", off, got_at(base + 1), model_stage);
            else n_pass++;
        end
    endtask

    task automatic test_auto_update();
        logic [31:0] r;
        int          base;
        ahb_write(3'd7, 32'h2);
        base = got_q.size();
        ahb_write(3'd1, $urandom);
        ahb_read(3'd7, r);
        n_checks++;
        if (r !== 32'h5) $display("FAIL auto_status: got %h, want 00000005", r); else n_pass++;
        wait_xfers(base + 1, 400);
        n_checks++;
        if (got_at(base) !== model_stage) $display("FAIL auto_snapshot: got %h, want %h", got_at(base), model_stage);
        else n_pass++;
        ahb_write(3'd7, 32'h0);
        repeat (40) @(negedge clk);
        n_checks++;
        if (got_q.size() !== base + 1) $display("FAIL auto_count: got %0d transfers, want 1", got_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] r;
        ahb_write(3'd0, 32'hDEAD_BEEF);
        ahb_read(3'd0, r);
        n_checks++;
        if (r !== 32'hDEAD_BEEF) $display("FAIL read_word0: got %h, want deadbeef", r); else n_pass++;
        ahb_read(3'd5, r);
        n_checks++;
        if (r !== 32'h0) $display("FAIL read_idx5: got %h, want 00000000", r); else n_pass++;
        ahb_read(3'd2, r);
        n_checks++;
        if (r !== 32'h0) $display("FAIL read_idx2: got %h, want 00000000", r); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        bit seen_latch;
        ahb_write(3'd0, $urandom);
        ahb_write(3'd7, 32'h1);
        repeat (60) @(negedge clk);
        base = got_q.size();
        #2 reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({shift, latch, serial_data_out, out_en_n, hrdata} !== {1'b0, 1'b0, {CN{1'b0}}, 1'b1, 32'h0})
            $display("FAIL midreset_outputs: got shift=%b latch=%b sdo=%b oen=%b hrdata=%h",
                     shift, latch, serial_data_out, out_en_n, hrdata);
        else n_pass++;
        model_stage = '0;
        model_auto  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen_latch = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (latch || shift) seen_latch = 1'b1;
        end
        n_checks++;
        if (seen_latch || got_q.size() != base)
            $display("FAIL midreset_aborted: activity=%b transfers=%0d, want 0 0", seen_latch, got_q.size() - base);
        else n_pass++;
        ahb_write(3'd0, $urandom);
        ahb_write(3'd1, $urandom);
        pulse_trigger();
        wait_xfers(base + 1, 400);
        n_checks++;
        if (got_at(base) !== model_stage) $display("FAIL midreset_retrigger: got %h, want %h", got_at(base), model_stage);
        else n_pass++;
        n_checks++;
        if (out_en_n !== 1'b0) $display("FAIL midreset_oen: got %b, want 0", out_en_n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_latch_boundary();
        test_auto_update();
        test_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_lim_output.md
SERIAL_LIM_OUTPUT -- requirements
Module: serial_lim_output

Interface
REQ-001 Parameters SHALL be: CHANNEL_NUM, default 6, number of parallel serial data lanes (one SIPO chain per lane); CHANNEL_DEPTH, default 8, bits per lane; CLK_DIV, default 10, clk cycles per shift-clock half period (0 treated as 1).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock.
- reset_n  in  1  reset; one clock; asynchronous, active-low.
- ahb_addr_valid  in  1  slave select.
- mem_ahb_htrans  in  2  AHB transfer type.
- mem_ahb_hready  in  1  AHB ready.
- mem_ahb_hwrite  in  1  AHB write.
- mem_ahb_haddr  in  32  AHB address.
- mem_ahb_hsize  in  3  AHB size (ignored).
- mem_ahb_hburst  in  3  AHB burst (ignored).
- mem_ahb_hwdata  in  32  AHB write data.
- mem_ahb_hreadyout  out  1  tied 1.
- mem_ahb_hresp  out  1  tied 0.
- mem_ahb_hrdata  out  32  registered read data.
- trigger  in  1  external update request, asynchronous.
- serial_data_out  out  CHANNEL_NUM  serial data, one bit per lane.
- shift  out  1  shift clock to SIPO chains.
- latch  out  1  storage-register latch pulse.
- out_en_n  out  1  output enable, active-low.

Function
REQ-003 DATA_WIDTH SHALL be CHANNEL_NUM*CHANNEL_DEPTH, and WORDS SHALL be ceil(DATA_WIDTH/32), which SHALL be at most 7.
REQ-004 Word index SHALL be haddr[4:2]; lane n SHALL occupy staging bits [n*CHANNEL_DEPTH +: CHANNEL_DEPTH], lane 0 in the LSBs.
REQ-005 Write transfer: address phase when ahb_addr_valid & htrans[1] & hready & hwrite; index captured; hwdata SHALL be applied on the next clk. Indices below WORDS write staging; bits above DATA_WIDTH SHALL be ignored.
REQ-006 Index 7 write SHALL be the control register: bit0=1 requests an update (self-clearing); bit1 = auto_update (stored; when 1, any staging write requests an update).
REQ-007 Reads SHALL register hrdata one cycle after the address phase: indices below WORDS return staging; index 7 returns {29'b0, auto_update, pending, busy}; other indices return 0.
REQ-008 trigger SHALL pass a 2-flop synchronizer; its rising edge SHALL request an update.
REQ-009 FSM states SHALL be IDLE, SHIFT, LATCH. In IDLE, a request or pending=1 SHALL snapshot staging into shadow, clear pending, and enter SHIFT.
REQ-010 SHIFT: per bit, serial_data_out[n] = shadow lane n bit (CHANNEL_DEPTH-1-k) for k=0..DEPTH-1 (MSB first), driven with shift low; shift low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-011 After the DEPTH-th high phase plus one low half period, the FSM SHALL enter LATCH: latch high for CLK_DIV cycles, then IDLE; out_en_n SHALL drop to 0 on the first completed latch and stay 0.
REQ-012 busy SHALL be 1 outside IDLE; a request while busy SHALL set pending (multiple coalesce to one) and the shadow SHALL be unaffected by mid-transfer staging writes.
REQ-013 A request in the same cycle as the LATCH to IDLE transition SHALL set pending; no request SHALL be lost.
REQ-014 In IDLE, shift, latch and serial_data_out SHALL be 0.

Reset
REQ-015 Reset SHALL clear staging, shadow, auto_update, pending, FSM (to IDLE), counters, synchronizer, hrdata, serial_data_out, shift and latch, and SHALL set out_en_n=1; a mid-transfer reset SHALL abort with no latch pulse.

Structure
REQ-016 A shared package SHALL hold the FSM state encoding, CTRL_INDEX=7, and the control bit positions.
REQ-017 Sub-module serial_tick_gen SHALL produce the CLK_DIV half-period tick, cleared whenever the FSM is IDLE.

Verification
REQ-018 Directed tests SHALL cover:
- Write word0=0x0403_0201, ctrl=1 -> lane0 stream 0,0,0,0,0,0,0,1 on 8 shift rises; latch pulse of 10 clk; busy cleared; out_en_n=0.
- CLK_DIV=10 -> shift high 10 clk and low 10 clk; total transfer 8*20+10+10 clk ±2.
- ctrl=1 three times while busy -> exactly one extra transfer; staging write mid-transfer absent from current stream and present in the next.
- auto_update=1, write word1 -> transfer starts without a ctrl write; read idx7 shows busy=1.
- Read idx0 after write 0xDEADBEEF -> hrdata=0xDEADBEEF one cycle later; idx5 -> 0.
- reset_n low mid-SHIFT -> all outputs 0, out_en_n=1, no latch pulse; next trigger edge -> full transfer.
